// File: rtl/riscv_irq_arbiter_pkg.sv
// Shared interrupt definitions: line packing, cause IDs and arbiter FSM states.
package riscv_defines;

    localparam int unsigned IRQ_NUM_FAST  = 15;
    localparam int unsigned IRQ_NUM_LINES = IRQ_NUM_FAST + 3;

    localparam logic [4:0] IRQ_ID_SW        = 5'd3;
    localparam logic [4:0] IRQ_ID_TIMER     = 5'd7;
    localparam logic [4:0] IRQ_ID_EXT       = 5'd11;
    localparam logic [4:0] IRQ_ID_FAST_BASE = 5'd16;

    // Bit order matches mie/mip: software is the MSB, fast[0] the LSB.
    typedef struct packed {
        logic                    software;
        logic                    timer;
        logic                    external;
        logic [IRQ_NUM_FAST-1:0] fast;
    } Interrupts_t;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQ,
        IRQ_DONE
    } irq_arb_state_e;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// Combinational 18-to-5 priority encoder mapping pending lines to a cause ID.
module riscv_irq_prio_enc
    import riscv_defines::*;
(
    input  logic [IRQ_NUM_LINES-1:0] pend,
    output logic                     valid,
    output logic [4:0]               id
);

    Interrupts_t p;

    assign p     = Interrupts_t'(pend);
    assign valid = |pend;

    // Assigned lowest priority first so later hits override earlier ones.
    always_comb begin
        id = '0;
        if (p.timer)    id = IRQ_ID_TIMER;
        if (p.software) id = IRQ_ID_SW;
        if (p.external) id = IRQ_ID_EXT;
        for (int unsigned k = 0; k < IRQ_NUM_FAST; k++) begin
            if (p.fast[k]) id = IRQ_ID_FAST_BASE + 5'(k);
        end
    end

endmodule

// File: rtl/riscv_irq_arbiter.sv
// Registers the level interrupt lines, selects the highest-priority enabled one
// and holds a frozen request towards the controller until ack or kill.
module riscv_irq_arbiter
    import riscv_defines::*;
#(
    parameter bit          SYNC_IRQ = 1'b0,
    parameter int unsigned NUM_FAST = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     irq_software_i,
    input  logic                     irq_timer_i,
    input  logic                     irq_external_i,
    input  logic [14:0]              irq_fast_i,
    input  logic [IRQ_NUM_LINES-1:0] mie_i,
    input  logic                     m_ie_i,
    input  logic                     ctrl_ack_i,
    input  logic                     ctrl_kill_i,
    output logic [IRQ_NUM_LINES-1:0] mip_o,
    output logic                     irq_req_o,
    output logic [4:0]               irq_id_o,
    output logic                     irq_busy_o
);

    if (NUM_FAST != IRQ_NUM_FAST) begin : g_bad_num_fast
        $error("riscv_irq_arbiter: NUM_FAST must equal IRQ_NUM_FAST");
    end

    Interrupts_t                raw;
    logic [IRQ_NUM_LINES-1:0]   line_in;
    logic [IRQ_NUM_LINES-1:0]   mip_q;
    logic                       sel_valid;
    logic [4:0]                 sel_id;
    logic                       any_pend;
    irq_arb_state_e             state_q, state_d;
    logic [4:0]                 id_q, id_d;

    assign raw = '{software: irq_software_i, timer: irq_timer_i,
                   external: irq_external_i, fast: irq_fast_i};

    if (SYNC_IRQ) begin : g_sync
        logic [IRQ_NUM_LINES-1:0] sync1_q, sync2_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= '0;
                sync2_q <= '0;
            end else begin
                sync1_q <= raw;
                sync2_q <= sync1_q;
            end
        end

        assign line_in = sync2_q;
    end else begin : g_nosync
        assign line_in = raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mip_q <= '0;
        else        mip_q <= line_in;
    end

    riscv_irq_prio_enc u_prio_enc (
        .pend  (mip_q & mie_i),
        .valid (sel_valid),
        .id    (sel_id)
    );

    assign any_pend = m_ie_i & sel_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IRQ_IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    // Enable changes during REQ are ignored; only kill withdraws the request.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IRQ_IDLE: begin
                if (any_pend) begin
                    id_d    = sel_id;
                    state_d = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                if (ctrl_ack_i)       state_d = IRQ_DONE;
                else if (ctrl_kill_i) state_d = IRQ_IDLE;
            end
            IRQ_DONE: state_d = IRQ_IDLE;
            default:  state_d = IRQ_IDLE;
        endcase
    end

    assign mip_o      = mip_q;
    assign irq_req_o  = (state_q == IRQ_REQ);
    assign irq_id_o   = id_q;
    assign irq_busy_o = (state_q != IRQ_IDLE);

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic on an
// unsynchronised and a synchronised arbiter, both against a reference model.
module tb_riscv_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw, tm, ex;
    logic [14:0] fast;
    logic [17:0] mie;
    logic        m_ie, ack, kill;

    logic [17:0] mip0, mip1;
    logic        req0, req1, busy0, busy1;
    logic [4:0]  id0, id1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_irq_arbiter #(.SYNC_IRQ(1'b0), .NUM_FAST(15)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .irq_software_i(sw), .irq_timer_i(tm), .irq_external_i(ex), .irq_fast_i(fast),
        .mie_i(mie), .m_ie_i(m_ie), .ctrl_ack_i(ack), .ctrl_kill_i(kill),
        .mip_o(mip0), .irq_req_o(req0), .irq_id_o(id0), .irq_busy_o(busy0)
    );

    riscv_irq_arbiter #(.SYNC_IRQ(1'b1), .NUM_FAST(15)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .irq_software_i(sw), .irq_timer_i(tm), .irq_external_i(ex), .irq_fast_i(fast),
        .mie_i(mie), .m_ie_i(m_ie), .ctrl_ack_i(ack), .ctrl_kill_i(kill),
        .mip_o(mip1), .irq_req_o(req1), .irq_id_o(id1), .irq_busy_o(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: pin-to-mip delay line plus a 3-phase handshake.
    // phase: 0 idle, 1 requesting, 2 one-cycle cooldown after ack.
    logic [17:0] pipe [2][3];
    int          phase [2];
    logic [4:0]  mid [2];

    function automatic logic [5:0] pick(input logic [17:0] p);
        for (int k = 14; k >= 0; k--) if (p[k]) return {1'b1, 5'(16 + k)};
        if (p[15]) return {1'b1, 5'd11};
        if (p[17]) return {1'b1, 5'd3};
        if (p[16]) return {1'b1, 5'd7};
        return '0;
    endfunction

    function automatic logic [17:0] mip_exp(input int i);
        return (i == 0) ? pipe[0][0] : pipe[1][2];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                phase[i] = 0;
                mid[i]   = '0;
                for (int j = 0; j < 3; j++) pipe[i][j] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                logic [5:0] pk;
                pk = pick(mip_exp(i) & mie);
                case (phase[i])
                    0: if (m_ie && pk[5]) begin mid[i] = pk[4:0]; phase[i] = 1; end
                    1: if (ack) phase[i] = 2; else if (kill) phase[i] = 0;
                    default: phase[i] = 0;
                endcase
                pipe[i][2] = pipe[i][1];
                pipe[i][1] = pipe[i][0];
                pipe[i][0] = {sw, tm, ex, fast};
            end
        end
    end

    always @(negedge clk) begin
        check("mip0",  32'(mip0),  32'(mip_exp(0)));
        check("req0",  32'(req0),  32'(phase[0] == 1));
        check("id0",   32'(id0),   32'(mid[0]));
        check("busy0", 32'(busy0), 32'(phase[0] != 0));
        check("mip1",  32'(mip1),  32'(mip_exp(1)));
        check("req1",  32'(req1),  32'(phase[1] == 1));
        check("id1",   32'(id1),   32'(mid[1]));
        check("busy1", 32'(busy1), 32'(phase[1] != 0));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!req0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(req0), 32'd1);
    endtask

    task automatic lines(input logic s, input logic t, input logic e, input logic [14:0] f);
        sw = s; tm = t; ex = e; fast = f;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        lines(1, 1, 1, '1);
        mie = '0; m_ie = 1'b0; ack = 1'b0; kill = 1'b0;

        // Reset holds everything at zero even with all lines high.
        tick();
        check("rst_mip", 32'(mip0), 32'd0);
        check("rst_req", 32'(req0), 32'd0);
        check("rst_id",  32'(id0),  32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_mip", 32'(mip0), 32'h3FFFF);
        check("idle_req", 32'(req0), 32'd0);
        tick();
        check("idle_req2", 32'(req0), 32'd0);
        lines(0, 0, 0, '0);
        repeat (4) tick();

        // Single timer line: request two cycles after the pin.
        m_ie = 1'b1; mie = '1;
        lines(0, 1, 0, '0);
        tick();
        check("tm_req_early", 32'(req0), 32'd0);
        tick();
        check("tm_req", 32'(req0), 32'd1);
        check("tm_id",  32'(id0),  32'd7);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        lines(0, 0, 0, '0);
        check("tm_done_req",  32'(req0),  32'd0);
        check("tm_done_busy", 32'(busy0), 32'd1);
        tick();
        check("tm_idle_busy", 32'(busy0), 32'd0);
        repeat (2) tick();

        // Priority order.
        lines(1, 0, 1, 15'h0004);
        wait_req("prio_a_wait");
        check("prio_fast2", 32'(id0), 32'd18);
        ack = 1'b1; lines(1, 0, 1, '0);
        tick();
        ack = 1'b0;
        wait_req("prio_b_wait");
        check("prio_ext", 32'(id0), 32'd11);
        ack = 1'b1; lines(1, 1, 0, '0);
        tick();
        ack = 1'b0;
        wait_req("prio_c_wait");
        check("prio_sw", 32'(id0), 32'd3);
        ack = 1'b1; lines(0, 0, 0, '0);
        tick();
        ack = 1'b0;
        repeat (3) tick();

        // No preemption once granted.
        lines(0, 1, 0, '0);
        wait_req("nopre_wait");
        check("nopre_id", 32'(id0), 32'd7);
        fast = 15'h4000;
        repeat (3) begin
            tick();
            check("nopre_hold", 32'(id0), 32'd7);
        end
        ack = 1'b1; tm = 1'b0;
        tick();
        ack = 1'b0;
        wait_req("rearb_wait");
        check("rearb_id", 32'(id0), 32'd30);
        ack = 1'b1; lines(0, 0, 0, '0);
        tick();
        ack = 1'b0;
        repeat (3) tick();

        // Kill alone, then ack+kill together.
        lines(0, 1, 0, '0);
        wait_req("kill_wait");
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_req",  32'(req0),  32'd0);
        check("kill_busy", 32'(busy0), 32'd0);
        tick();
        check("kill_rereq", 32'(req0), 32'd1);
        check("kill_reid",  32'(id0),  32'd7);
        ack = 1'b1; kill = 1'b1;
        tick();
        ack = 1'b0; kill = 1'b0;
        check("ackkill_req",  32'(req0),  32'd0);
        check("ackkill_busy", 32'(busy0), 32'd1);
        lines(0, 0, 0, '0);

        // Flush both arbiters, then exercise the synchronised path.
        m_ie = 1'b0; kill = 1'b1;
        tick();
        kill = 1'b0;
        repeat (5) tick();
        m_ie = 1'b1;
        ex = 1'b1;
        tick();
        ex = 1'b0;
        check("sync_mip_p1", 32'(mip1[15]), 32'd0);
        tick();
        check("sync_mip_p2", 32'(mip1[15]), 32'd0);
        tick();
        check("sync_mip_p3", 32'(mip1[15]), 32'd1);
        check("sync_req_p3", 32'(req1), 32'd0);
        tick();
        check("sync_req_p4", 32'(req1), 32'd1);
        check("sync_id_p4",  32'(id1),  32'd11);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req1",  32'(req1),  32'd0);
        check("arst_busy1", 32'(busy1), 32'd0);
        check("arst_req0",  32'(req0),  32'd0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int b = 0; b < 15; b++) fast[b] = ($urandom_range(0, 15) == 0);
            sw   = ($urandom_range(0, 5) == 0);
            tm   = ($urandom_range(0, 5) == 0);
            ex   = ($urandom_range(0, 5) == 0);
            mie  = 18'($urandom);
            m_ie = ($urandom_range(0, 3) != 0);
            ack  = ($urandom_range(0, 2) == 0);
            kill = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
